systolic_matmul_nxn: RTL and testbench

//  Parametrised NxN output-stationary systolic matrix multiplier, successor to the fixed 2x2 unit.

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/systolic_matmul_nxn_if.sv | 35 +++
 rtl/systolic_pe.sv | 58 +++++
 rtl/systolic_matmul_nxn.sv | 193 +++++++++++++++++++
 tb/tb_systolic_matmul_nxn.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the NxN output-stationary systolic matrix multiplier.
package systolic_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StFlush,
        StDrain
    } state_e;

    localparam int unsigned MinN = 2;
    localparam int unsigned MaxN = 8;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2(int unsigned value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    function automatic bit n_is_legal(int unsigned n);
        return (n >= MinN) && (n <= MaxN);
    endfunction

endpackage

// File: rtl/systolic_matmul_nxn_if.sv
// Operand stream, result stream and job control of the systolic multiplier.
interface systolic_matmul_nxn_if
    import systolic_pkg::*;
#(
    parameter int unsigned N      = 2,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 32
) ();

    localparam int unsigned IDX_W = clog2(N);

    logic                  start;
    logic                  acc_mode;
    logic                  in_valid;
    logic                  in_ready;
    logic [N*DATA_W-1:0]   a_col;
    logic [N*DATA_W-1:0]   b_row;
    logic                  c_valid;
    logic                  c_ready;
    logic [N*ACC_W-1:0]    c_row;
    logic [IDX_W-1:0]      c_row_idx;
    logic                  busy;
    logic                  done;

    modport master (
        output start, acc_mode, in_valid, a_col, b_row, c_ready,
        input  in_ready, c_valid, c_row, c_row_idx, busy, done
    );

    modport slave (
        input  start, acc_mode, in_valid, a_col, b_row, c_ready,
        output in_ready, c_valid, c_row, c_row_idx, busy, done
    );

endinterface

// File: rtl/systolic_pe.sv
// Output-stationary processing element: accumulates a*b per step, forwards a right and b down.
module systolic_pe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 32,
    parameter bit          SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);

    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    prod_ext;

    // Low 2*DATA_W bits of the extended-operand product are exact for both signednesses.
    always_comb begin
        if (SIGNED) begin
            a_ext = {{DATA_W{a_in[DATA_W-1]}}, a_in};
            b_ext = {{DATA_W{b_in[DATA_W-1]}}, b_in};
        end else begin
            a_ext = {{DATA_W{1'b0}}, a_in};
            b_ext = {{DATA_W{1'b0}}, b_in};
        end
        prod = a_ext * b_ext;
        if (SIGNED) begin
            prod_ext = ACC_W'($signed(prod));
        end else begin
            prod_ext = ACC_W'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            if (clr) begin
                acc <= '0;
            end else if (en) begin
                acc <= acc + prod_ext;
            end
            if (en) begin
                a_out <= a_in;
                b_out <= b_in;
            end
        end
    end

endmodule

// File: rtl/systolic_matmul_nxn.sv
// NxN output-stationary systolic multiplier: skewed operand feed, PE grid, flush and row drain.
module systolic_matmul_nxn
    import systolic_pkg::*;
#(
    parameter int unsigned N      = 2,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 32,
    parameter bit          SIGNED = 1'b0
) (
    input logic                 clk,
    input logic                 reset,
    systolic_matmul_nxn_if.slave bus
);

    localparam int unsigned IDX_W  = clog2(N);
    localparam int unsigned CNT_W  = clog2(2 * N);
    localparam bit          NLegal = n_is_legal(N);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   beat_q, beat_d;
    logic [IDX_W-1:0]   row_q, row_d;
    logic [IDX_W-1:0]   c_idx_q, c_idx_d;
    logic [IDX_W-1:0]   row_sel;
    logic [CNT_W-1:0]   flush_q, flush_d;
    logic               c_valid_q, c_valid_d;
    logic [N*ACC_W-1:0] c_row_q, c_row_d;
    logic [N*ACC_W-1:0] row_data;
    logic               fire;
    logic               advance;
    logic               clr;
    logic               done_pulse;

    logic [DATA_W-1:0] a_inj  [N];
    logic [DATA_W-1:0] b_inj  [N];
    logic [DATA_W-1:0] a_pipe [N][N+1];
    logic [DATA_W-1:0] b_pipe [N+1][N];
    logic [ACC_W-1:0]  acc    [N][N];

    n_legal_a: assert property (@(posedge clk) NLegal);

    for (genvar i = 0; i < N; i++) begin : g_edge
        assign a_inj[i] = fire ? bus.a_col[i*DATA_W +: DATA_W] : '0;
        assign b_inj[i] = fire ? bus.b_row[i*DATA_W +: DATA_W] : '0;

        if (i == 0) begin : g_direct
            assign a_pipe[i][0] = a_inj[i];
            assign b_pipe[0][i] = b_inj[i];
        end else begin : g_delay
            // Row/column i enters the grid i steps late so matching k terms meet in each PE.
            logic [DATA_W-1:0] a_sr [i];
            logic [DATA_W-1:0] b_sr [i];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < i; k++) begin
                        a_sr[k] <= '0;
                        b_sr[k] <= '0;
                    end
                end else if (advance) begin
                    a_sr[0] <= a_inj[i];
                    b_sr[0] <= b_inj[i];
                    for (int k = 1; k < i; k++) begin
                        a_sr[k] <= a_sr[k-1];
                        b_sr[k] <= b_sr[k-1];
                    end
                end
            end

            assign a_pipe[i][0] = a_sr[i-1];
            assign b_pipe[0][i] = b_sr[i-1];
        end

        logic unused_a_edge;
        logic unused_b_edge;
        assign unused_a_edge = ^a_pipe[i][N];
        assign unused_b_edge = ^b_pipe[N][i];

        assign row_data[i*ACC_W +: ACC_W] = acc[row_sel][i];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) u_pe (
                .clk   (clk),
                .reset (reset),
                .en    (advance),
                .clr   (clr),
                .a_in  (a_pipe[i][j]),
                .b_in  (b_pipe[i][j]),
                .a_out (a_pipe[i][j+1]),
                .b_out (b_pipe[i+1][j]),
                .acc   (acc[i][j])
            );
        end
    end

    // Row to load into the output register: the next row once the current one is taken.
    assign row_sel = (state_q == StDrain && c_valid_q) ? row_q + 1'b1 : row_q;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        flush_d    = flush_q;
        row_d      = row_q;
        c_valid_d  = c_valid_q;
        c_row_d    = c_row_q;
        c_idx_d    = c_idx_q;
        fire       = 1'b0;
        advance    = 1'b0;
        clr        = 1'b0;
        done_pulse = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    clr     = !bus.acc_mode;
                    beat_d  = '0;
                    state_d = StFeed;
                end
            end
            StFeed: begin
                if (bus.in_valid) begin
                    fire    = 1'b1;
                    advance = 1'b1;
                    if (beat_q == IDX_W'(N - 1)) begin
                        flush_d = '0;
                        state_d = StFlush;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StFlush: begin
                advance = 1'b1;
                if (flush_q == CNT_W'(2 * N - 3)) begin
                    row_d   = '0;
                    state_d = StDrain;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            StDrain: begin
                if (!c_valid_q) begin
                    c_valid_d = 1'b1;
                    c_row_d   = row_data;
                    c_idx_d   = row_q;
                end else if (bus.c_ready) begin
                    if (row_q == IDX_W'(N - 1)) begin
                        c_valid_d  = 1'b0;
                        done_pulse = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        row_d   = row_sel;
                        c_row_d = row_data;
                        c_idx_d = row_sel;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            flush_q   <= '0;
            row_q     <= '0;
            c_valid_q <= 1'b0;
            c_row_q   <= '0;
            c_idx_q   <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            flush_q   <= flush_d;
            row_q     <= row_d;
            c_valid_q <= c_valid_d;
            c_row_q   <= c_row_d;
            c_idx_q   <= c_idx_d;
        end
    end

    assign bus.in_ready  = (state_q == StFeed);
    assign bus.busy      = (state_q != StIdle);
    assign bus.c_valid   = c_valid_q;
    assign bus.c_row     = c_row_q;
    assign bus.c_row_idx = c_idx_q;
    assign bus.done      = done_pulse;

endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// Randomised bench for two multiplier instances (N=2 unsigned, N=4 signed) against a matrix model.
module tb_systolic_matmul_nxn;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   sel   = 1'b0;  // 0: N=2 unsigned instance, 1: N=4 signed instance

    logic start    = 1'b0;
    logic acc_mode = 1'b0;
    logic in_valid = 1'b0;
    logic c_ready  = 1'b0;
    logic [3:0][DW-1:0] a_v = '0;
    logic [3:0][DW-1:0] b_v = '0;

    logic            in_ready_s, c_valid_s, busy_s, done_s;
    logic [1:0]      idx_s;
    logic [4*AW-1:0] row_s;

    logic [DW-1:0] ma [4][4];
    logic [DW-1:0] mb [4][4];
    longint        mdl [2][4][4];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    systolic_matmul_nxn_if #(.N(2), .DATA_W(DW), .ACC_W(AW)) bus2 ();
    systolic_matmul_nxn_if #(.N(4), .DATA_W(DW), .ACC_W(AW)) bus4 ();

    assign bus2.start    = start & ~sel;
    assign bus2.acc_mode = acc_mode;
    assign bus2.in_valid = in_valid & ~sel;
    assign bus2.a_col    = a_v[1:0];
    assign bus2.b_row    = b_v[1:0];
    assign bus2.c_ready  = c_ready & ~sel;

    assign bus4.start    = start & sel;
    assign bus4.acc_mode = acc_mode;
    assign bus4.in_valid = in_valid & sel;
    assign bus4.a_col    = a_v;
    assign bus4.b_row    = b_v;
    assign bus4.c_ready  = c_ready & sel;

    systolic_matmul_nxn #(.N(2), .DATA_W(DW), .ACC_W(AW), .SIGNED(1'b0)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    systolic_matmul_nxn #(.N(4), .DATA_W(DW), .ACC_W(AW), .SIGNED(1'b1)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    always_comb begin
        if (sel) begin
            in_ready_s = bus4.in_ready;
            c_valid_s  = bus4.c_valid;
            busy_s     = bus4.busy;
            done_s     = bus4.done;
            idx_s      = bus4.c_row_idx;
            row_s      = bus4.c_row;
        end else begin
            in_ready_s = bus2.in_ready;
            c_valid_s  = bus2.c_valid;
            busy_s     = bus2.busy;
            done_s     = bus2.done;
            idx_s      = {1'b0, bus2.c_row_idx};
            row_s      = {64'b0, bus2.c_row};
        end
    end

    always @(posedge clk) if (done_s) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (N=%0d) at %0t: observed 0x%0h, expected 0x%0h",
                     tag, sel ? 4 : 2, $time, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] c_elem(input int j);
        return row_s[j*AW +: AW];
    endfunction

    function automatic longint ext(input logic [DW-1:0] v);
        return sel ? longint'($signed(v)) : longint'(v);
    endfunction

    function automatic logic [63:0] exp_elem(input int r, input int j);
        return 64'(mdl[sel][r][j] & 64'hFFFF_FFFF);
    endfunction

    task automatic clear_model();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) mdl[s][i][j] = 0;
    endtask

    task automatic load_first();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = '0;
                mb[i][j] = '0;
            end
        ma[0][0] = 16'd1; ma[0][1] = 16'd2; ma[1][0] = 16'd3; ma[1][1] = 16'd4;
        mb[0][0] = 16'd5; mb[0][1] = 16'd6; mb[1][0] = 16'd7; mb[1][1] = 16'd8;
    endtask

    task automatic load_random();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = DW'($urandom);
                mb[i][j] = DW'($urandom);
            end
    endtask

    // Called at a negedge with the selected instance idle; returns at the negedge after the last beat.
    task automatic feed_job(input bit acc, input bit gaps);
        int n;
        n = sel ? 4 : 2;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                if (!acc) mdl[sel][i][j] = 0;
                for (int k = 0; k < n; k++) mdl[sel][i][j] += ext(ma[i][k]) * ext(mb[k][j]);
            end
        start    = 1'b1;
        acc_mode = acc;
        @(negedge clk);
        start    = 1'b0;
        acc_mode = 1'($urandom_range(0, 1));
        check("busy_in_feed", 64'(busy_s), 64'(1));
        check("in_ready_in_feed", 64'(in_ready_s), 64'(1));
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                a_v = {$urandom(), $urandom()};
                b_v = {$urandom(), $urandom()};
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            for (int i = 0; i < 4; i++) begin
                a_v[i] = ma[i][k];
                b_v[i] = mb[k][i];
            end
            in_valid = 1'b1;
            @(negedge clk);
        end
        // With gaps, also offer junk beats and a stray start while flushing.
        in_valid = gaps;
        start    = gaps;
        a_v = {$urandom(), $urandom()};
        b_v = {$urandom(), $urandom()};
    endtask

    task automatic drain_job(input int stall);
        int n, cyc, d0;
        n   = sel ? 4 : 2;
        cyc = 0;
        d0  = done_cnt;
        while (!c_valid_s && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                in_valid = 1'b0;
                start    = 1'b0;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("first_valid_latency", 64'(cyc), 64'(2 * n - 1));
        if (!c_valid_s) return;
        for (int r = 0; r < n; r++) begin
            check("c_valid", 64'(c_valid_s), 64'(1));
            check("c_row_idx", 64'(idx_s), 64'(r));
            for (int j = 0; j < n; j++) check("c_elem", 64'(c_elem(j)), exp_elem(r, j));
            if (r == 0) begin
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    check("stall_valid", 64'(c_valid_s), 64'(1));
                    check("stall_idx", 64'(idx_s), 64'(0));
                    for (int j = 0; j < n; j++) check("stall_elem", 64'(c_elem(j)), exp_elem(0, j));
                end
            end
            c_ready = 1'b1;
            #1;
            check("done", 64'(done_s), 64'(r == n - 1));
            @(negedge clk);
            c_ready = 1'b0;
        end
        check("c_valid_after_drain", 64'(c_valid_s), 64'(0));
        check("busy_after_drain", 64'(busy_s), 64'(0));
        check("done_pulse_count", 64'(done_cnt - d0), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready_s), 64'(0));
        check({tag, "_c_valid"}, 64'(c_valid_s), 64'(0));
        check({tag, "_busy"}, 64'(busy_s), 64'(0));
        check({tag, "_done"}, 64'(done_s), 64'(0));
        check({tag, "_idx"}, 64'(idx_s), 64'(0));
        for (int j = 0; j < 4; j++) check({tag, "_row"}, 64'(c_elem(j)), 64'(0));
    endtask

    initial begin
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check_reset_outputs("reset");
        end

        sel = 1'b0;
        load_first();
        feed_job(1'b0, 1'b0);
        drain_job(0);
        feed_job(1'b1, 1'b0);
        drain_job(0);
        feed_job(1'b0, 1'b1);
        drain_job(3);

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 16'hFFFF;
                mb[i][j] = 16'hFFFF;
            end
        feed_job(1'b0, 1'b0);
        drain_job(1);

        for (int t = 0; t < 4; t++) begin
            load_random();
            feed_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drain_job(int'($urandom_range(0, 3)));
        end

        sel = 1'b1;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = (i == j) ? 16'hFFFF : 16'h0000;
                mb[i][j] = DW'(i * 4 + j);
            end
        feed_job(1'b0, 1'b0);
        drain_job(0);
        for (int t = 0; t < 3; t++) begin
            load_random();
            feed_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drain_job(int'($urandom_range(0, 3)));
        end

        // Abort during flush, then accumulate onto the cleared array.
        sel = 1'b0;
        load_random();
        feed_job(1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        check("busy_after_abort", 64'(busy_s), 64'(0));
        check("c_valid_after_abort", 64'(c_valid_s), 64'(0));
        repeat (6) @(negedge clk);
        check("c_valid_idle_after_abort", 64'(c_valid_s), 64'(0));
        load_first();
        feed_job(1'b1, 1'b0);
        drain_job(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected completion before %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
